bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Master-side requester that sits directly upstream of the bus arbiter, one instance per master on the shared CMD3 local bus.
- Accepts single read/write commands from local logic and raises barq to the arbiter.
- Once bagd is received, drives address, write data and direction onto the shared bus. It completes on data_strobe, or retries/fails on the arbiter's timeout error pulse.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- MAX_RETRY, 3, number of re-arbitrations allowed after a timeout before an error response is returned (0 = no retry).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  port can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_error  out  1  transaction failed, valid with rsp_valid
- barq  out  1  bus access request to arbiter
- bagd  in  1  bus access granted for this master
- data_strobe  in  1  arbiter completion strobe
- error  in  1  arbiter timeout pulse
- bus_oe  out  1  enables this master's bus drivers
- bus_addr  out  ADDR_WIDTH  driven address
- bus_wdata  out  DATA_WIDTH  driven write data
- bus_write  out  1  driven direction
- bus_rdata  in  DATA_WIDTH  shared read-data bus

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; retry_cnt and err_flag clear.
  - All outputs 0 except cmd_ready, which goes to 1.
  - A reset mid-transaction drops barq/bus_oe at once; the arbiter recovers via its own end_cycle.
- All outputs are registered. There are five states.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid & cmd_ready latches write/addr/wdata, clears retry_cnt, and moves to REQ.
  - barq is high from the next cycle (1-cycle latency).
- REQ:
  - barq = 1, cmd_ready = 0, bus_oe = 0.
  - bagd sampled high moves to OWN.
  - No timeout while waiting for a grant; waiting is unbounded.
- OWN:
  - barq = 1, bus_oe = 1; bus_addr/bus_wdata/bus_write hold the latched command.
  - error sampled high sets sticky err_flag. The strobe follows the error pulse by 2 cycles.
  - data_strobe with err_flag = 0: capture bus_rdata on reads (write responses return 0), then go to RESP with rsp_error = 0.
  - data_strobe with err_flag = 1 and retry_cnt < MAX_RETRY: retry_cnt+1, clear err_flag, go to GAP.
  - data_strobe with err_flag = 1 and retry_cnt = MAX_RETRY: go to RESP with rsp_error = 1 and rsp_rdata = 0.
  - bagd low before data_strobe: protocol fault; go to RESP with rsp_error = 1 and no retry.
  - error and data_strobe in the same cycle: err_flag is treated as set.
- GAP:
  - barq = 0, bus_oe = 0 for exactly 2 cycles so the arbiter's grant mask clears, then REQ.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with barq and bus_oe low; next state is IDLE.
  - Minimum command-to-command spacing is therefore one RESP cycle plus one IDLE accept.
- Driver and request timing: bus_oe and barq fall in the cycle after data_strobe is sampled. bus_oe is never high outside OWN.
- Width rules: retry_cnt is $clog2(MAX_RETRY+1) bits, minimum 1; it saturates at MAX_RETRY.

Decomposition:
- Shared package bus_pkg:
  - typedef enum master_state_t {IDLE, REQ, OWN, GAP, RESP}
  - GAP_CYCLES = 2
  - default ADDR_WIDTH/DATA_WIDTH constants, reused by the arbiter and targets.
- No sub-module; a single FSM plus command/response registers. The retry counter and GAP counter are inline.

Test Plan:
- Read, grant after 3 cycles, strobe 4 cycles later with bus_rdata = 16'hA5C3 -> barq high at cycle 1; bus_oe for the whole grant; one rsp_valid with rsp_rdata = A5C3 and rsp_error = 0; cmd_ready back high next cycle.
- Write addr 16'h0010, data 16'h1234 -> bus_addr = 0010, bus_wdata = 1234, bus_write = 1 while bus_oe = 1; rsp_valid with rsp_error = 0 and rsp_rdata = 0.
- MAX_RETRY = 3, arbiter error + strobe on every attempt -> 4 grants total, each separated by 2 barq-low cycles; final rsp_error = 1.
- Error on the first attempt only, second attempt strobes with 16'h00FF -> exactly one retry; rsp_rdata = 00FF, rsp_error = 0.
- bagd dropped mid-OWN with no strobe -> rsp_error = 1 on the next cycle; no retry; barq low.
- reset asserted during OWN -> barq, bus_oe and rsp_valid go 0 immediately; cmd_ready = 1 after release; a new command completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared CMD3 local-bus definitions.
// Used by the master ports, the arbiter and the bus targets.
package bus_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OWN,
    GAP,
    RESP
  } master_state_t;

endpackage

// File: rtl/bus_master_port.sv
// Master-side requester for the shared CMD3 local bus.
// Requests the bus, drives one command, retries on arbiter timeout.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  barq,
  input  logic                  bagd,
  input  logic                  data_strobe,
  input  logic                  error,
  output logic                  bus_oe,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_write,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  master_state_t   state_q;
  logic [RW-1:0]   retry_q;
  logic [GW-1:0]   gap_q;
  logic            err_q;
  logic            write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic            cmd_ready_q;
  logic            barq_q;
  logic            oe_q;
  logic            rsp_valid_q;
  logic            rsp_error_q;

  logic            err_d;
  logic            can_retry_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Attempt outcome: a timeout coincident with the strobe still counts.
  always_comb begin
    err_d       = err_q | error;
    can_retry_d = (retry_q < RMAX);
    rdata_d     = write_q ? '0 : bus_rdata;
  end

  // Request/ownership FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      barq_q      <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            retry_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            barq_q      <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bagd) begin
            oe_q    <= 1'b1;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (data_strobe) begin
            barq_q <= 1'b0;
            oe_q   <= 1'b0;
            if (!err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b0;
              rdata_q     <= rdata_d;
              state_q     <= RESP;
            end else if (can_retry_d) begin
              retry_q <= retry_q + 1'b1;
              err_q   <= 1'b0;
              gap_q   <= '0;
              state_q <= GAP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rdata_q     <= '0;
              state_q     <= RESP;
            end
          end else if (!bagd) begin
            barq_q      <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rdata_q     <= '0;
            state_q     <= RESP;
          end else if (error) begin
            err_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GLAST) begin
            barq_q  <= 1'b1;
            state_q <= REQ;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          err_q       <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = rsp_error_q;
  assign barq      = barq_q;
  assign bus_oe    = oe_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_write = write_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table vectors, reset-in-OWN, random txns.
// The bench plays the arbiter and scores each response.
module tb_bus_master_port;

  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        barq;
  logic        bagd;
  logic        data_strobe;
  logic        error;
  logic        bus_oe;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_write;
  logic [15:0] bus_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .MAX_RETRY (MR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .barq       (barq),
    .bagd       (bagd),
    .data_strobe(data_strobe),
    .error      (error),
    .bus_oe     (bus_oe),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_write  (bus_write),
    .bus_rdata  (bus_rdata)
  );

  // Per-attempt arbiter behaviour (2 bits each, attempt 0 in [1:0]):
  // 0 clean strobe at sdly, 1 error then strobe 2 later,
  // 2 error and strobe together at sdly, 3 grant dropped at sdly.
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [7:0]  modes;
    int          gdly;
    int          sdly;
    logic        exp_err;
    logic [15:0] exp_rd;
    int          exp_gr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] rd,
                              input logic [7:0] m, input int g, input int s,
                              input logic ee, input logic [15:0] er,
                              input int eg);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.rdata = rd; v.modes = m;
    v.gdly = g; v.sdly = s; v.exp_err = ee; v.exp_rd = er; v.exp_gr = eg;
    return v;
  endfunction

  // Response model: walk attempts until success, drop or retries exhausted.
  function automatic void model(inout vec_t v);
    logic [1:0] m;
    v.exp_err = 1'b1;
    v.exp_rd  = '0;
    v.exp_gr  = 0;
    for (int a = 0; a <= MR; a++) begin
      m = v.modes[2*a +: 2];
      v.exp_gr++;
      if (m == 2'd0) begin
        v.exp_err = 1'b0;
        v.exp_rd  = v.wr ? 16'h0 : v.rdata;
        break;
      end
      if (m == 2'd3) break;
    end
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int cyc, att, k, wait_cnt, low_run, gr;
    bit granted, fired, done;
    logic [1:0] m;
    m = 2'd0;
    @(negedge clk);
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    att = 0; k = 0; wait_cnt = 0; low_run = 0; gr = 0;
    granted = 0; fired = 0; done = 0;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_addr    = 16'($urandom);
      cmd_wdata   = 16'($urandom);
      cmd_write   = 1'($urandom);
      error       = 1'b0;
      data_strobe = 1'b0;
      bus_rdata   = 16'($urandom);
      if (cyc == 0) chk({tag, ".barq_lat"}, {31'd0, barq}, 32'd1);
      if (bus_oe) begin
        chk({tag, ".oe_granted"}, {31'd0, granted}, 32'd1);
        chk({tag, ".bus_addr"}, {16'd0, bus_addr}, {16'd0, v.addr});
        chk({tag, ".bus_wdata"}, {16'd0, bus_wdata}, {16'd0, v.wdata});
        chk({tag, ".bus_write"}, {31'd0, bus_write}, {31'd0, v.wr});
      end
      if (rsp_valid) begin
        done = 1;
        bagd = 1'b0;
        chk({tag, ".rsp_error"}, {31'd0, rsp_error}, {31'd0, v.exp_err});
        chk({tag, ".rsp_rdata"}, {16'd0, rsp_rdata}, {16'd0, v.exp_rd});
        chk({tag, ".grants"}, gr, v.exp_gr);
        chk({tag, ".rsp_barq_oe"}, {30'd0, barq, bus_oe}, 32'd0);
      end else if (!granted) begin
        if (barq) begin
          if (gr > 0 && low_run > 0) begin
            chk({tag, ".gap_len"}, low_run, 2);
            low_run = 0;
          end
          wait_cnt++;
          if (wait_cnt >= v.gdly) begin
            bagd    = 1'b1;
            granted = 1;
            fired   = 0;
            k       = 0;
            gr++;
            m = (att < 4) ? v.modes[2*att +: 2] : 2'd0;
          end
        end else if (gr > 0) begin
          low_run++;
        end
      end else if (fired) begin
        chk({tag, ".release"}, {30'd0, barq, bus_oe}, 32'd0);
        bagd     = 1'b0;
        granted  = 0;
        att++;
        wait_cnt = 0;
        low_run  = 1;
      end else begin
        k++;
        chk({tag, ".oe_own"}, {31'd0, bus_oe}, 32'd1);
        case (m)
          2'd0: if (k == v.sdly) begin
            data_strobe = 1'b1; bus_rdata = v.rdata; fired = 1;
          end
          2'd1: if (k == 1) error = 1'b1;
          else if (k == 3) begin
            data_strobe = 1'b1; bus_rdata = v.rdata; fired = 1;
          end
          2'd2: if (k == v.sdly) begin
            error = 1'b1; data_strobe = 1'b1; bus_rdata = v.rdata; fired = 1;
          end
          default: if (k == v.sdly) begin
            bagd = 1'b0; granted = 0;
          end
        endcase
      end
    end
    if (!done) begin
      $display("FAIL %s.timeout actual=no_rsp required=rsp", tag);
      n_total++;
      bagd = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".single_rsp"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_wdata = 0; bagd = 0; data_strobe = 0; error = 0; bus_rdata = 0;

    vecs[0] = mk(0, 16'h0100, 16'h0000, 16'hA5C3, 8'h00, 3, 4, 0, 16'hA5C3, 1);
    vecs[1] = mk(1, 16'h0010, 16'h1234, 16'hBEEF, 8'h00, 1, 2, 0, 16'h0000, 1);
    vecs[2] = mk(0, 16'h0200, 16'h0000, 16'h5555, 8'h55, 2, 3, 1, 16'h0000, 4);
    vecs[3] = mk(0, 16'h0300, 16'h0000, 16'h00FF, 8'h01, 1, 3, 0, 16'h00FF, 2);
    vecs[4] = mk(0, 16'h0400, 16'h0000, 16'h1111, 8'h03, 2, 2, 1, 16'h0000, 1);
    vecs[5] = mk(1, 16'h0500, 16'h9876, 16'h7777, 8'h0E, 1, 1, 1, 16'h0000, 2);
    vecs[6] = mk(0, 16'h0600, 16'h0000, 16'h4242, 8'hAA, 3, 2, 1, 16'h0000, 4);

    repeat (2) @(negedge clk);
    chk("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst.outs", {28'd0, barq, bus_oe, rsp_valid, rsp_error}, 32'd0);
    chk("rst.data", {rsp_rdata, bus_addr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while the port owns the bus.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0777;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstown.barq", {31'd0, barq}, 32'd1);
    bagd = 1'b1;
    @(negedge clk);
    chk("rstown.oe", {31'd0, bus_oe}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstown.drop", {29'd0, barq, bus_oe, rsp_valid}, 32'd0);
    chk("rstown.ready", {31'd0, cmd_ready}, 32'd1);
    bagd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_txn(vecs[0], "post_rst");

    for (int i = 0; i < 30; i++) begin
      v.wr    = 1'($urandom);
      v.addr  = 16'($urandom);
      v.wdata = 16'($urandom);
      v.rdata = 16'($urandom);
      v.modes = 8'($urandom);
      v.gdly  = $urandom_range(1, 4);
      v.sdly  = $urandom_range(1, 5);
      model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
